// File: rtl/hzd_ctrl.sv
// Pipeline hazard controller: load-use bubbles, fixed-latency multicycle holds of E, taken-branch flushes.
// Optional perf counters are built when HZD_PERF_EN is defined; otherwise both counter ports read 0.
module hzd_ctrl #(
  parameter int REG_SELECT = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_SELECT-1:0] i_reg_a_select,
  input  logic [REG_SELECT-1:0] i_reg_b_select,
  input  logic                  i_uses_a,
  input  logic                  i_uses_b,
  input  logic                  i_is_load_E,
  input  logic [REG_SELECT-1:0] i_reg_c_select_E,
  input  logic                  i_mc_start_E,
  input  logic                  i_branch_taken_E,
  output logic                  o_stall_F,
  output logic                  o_stall_D,
  output logic                  o_stall_E,
  output logic                  o_flush_D,
  output logic                  o_flush_E,
  output logic                  o_mc_done,
  output logic                  o_mc_busy,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_flush_count
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 2);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;

  logic load_use;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, mc_done, mc_busy;

  assign load_use = i_is_load_E && (i_reg_c_select_E != '0) &&
                    ((i_uses_a && (i_reg_a_select == i_reg_c_select_E)) ||
                     (i_uses_b && (i_reg_b_select == i_reg_c_select_E)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    mc_done    = 1'b0;
    mc_busy    = 1'b0;
    case (state_reg)
      RUN: begin
        if (done_reg) begin
          // E still holds the completing op, so a new start must wait a cycle
          mc_done   = 1'b1;
          done_next = 1'b0;
        end else if (i_branch_taken_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (i_mc_start_E) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          if (MC_LATENCY == 2) begin
            done_next = 1'b1;
          end else begin
            cnt_next   = MC_LOAD;
            state_next = MC_WAIT;
          end
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MC_WAIT: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        mc_busy  = 1'b1;
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) begin
          done_next  = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Inputs feed the outputs combinationally, so reset must gate them directly
  assign o_stall_F = i_rst_n & stall_f;
  assign o_stall_D = i_rst_n & stall_d;
  assign o_stall_E = i_rst_n & stall_e;
  assign o_flush_D = i_rst_n & flush_d;
  assign o_flush_E = i_rst_n & flush_e;
  assign o_mc_done = i_rst_n & mc_done;
  assign o_mc_busy = i_rst_n & mc_busy;

`ifdef HZD_PERF_EN
  logic [1:0] perf_inc;
  assign perf_inc = {o_flush_D, o_stall_F};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [CNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign o_stall_cycles = g_perf[0].cnt_reg;
  assign o_flush_count  = g_perf[1].cnt_reg;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hzd_ctrl.sv
// Self-checking bench for hzd_ctrl: three instances (latency 4/2/6) share stimulus; a table, directed
// sequences and random traffic are checked against a cycle-age reference model.
module tb_hzd_ctrl;
  localparam int RS = 5;
  localparam int NI = 3;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 6;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    case (i)
      0:       return 4;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [RS-1:0] i_reg_a_select = '0, i_reg_b_select = '0, i_reg_c_select_E = '0;
  logic          i_uses_a = 1'b0, i_uses_b = 1'b0, i_is_load_E = 1'b0;
  logic          i_mc_start_E = 1'b0, i_branch_taken_E = 1'b0;

  logic [NI-1:0][6:0]  dout;
  logic [NI-1:0][31:0] dsc, dfc;

  always #5 i_clk = ~i_clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = cw_of(gi);
    logic [CW-1:0] sc, fc;
    logic sf, sd, se, fd, fe, dn, bz;
    hzd_ctrl #(.REG_SELECT(RS), .MC_LATENCY(lat_of(gi)), .CNT_WIDTH(CW)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_reg_a_select(i_reg_a_select), .i_reg_b_select(i_reg_b_select),
      .i_uses_a(i_uses_a), .i_uses_b(i_uses_b),
      .i_is_load_E(i_is_load_E), .i_reg_c_select_E(i_reg_c_select_E),
      .i_mc_start_E(i_mc_start_E), .i_branch_taken_E(i_branch_taken_E),
      .o_stall_F(sf), .o_stall_D(sd), .o_stall_E(se),
      .o_flush_D(fd), .o_flush_E(fe), .o_mc_done(dn), .o_mc_busy(bz),
      .o_stall_cycles(sc), .o_flush_count(fc)
    );
    assign dout[gi] = {sf, sd, se, fd, fe, dn, bz};
    assign dsc[gi]  = 32'(sc);
    assign dfc[gi]  = 32'(fc);
  end

  // Output vector bit order: {stall_F, stall_D, stall_E, flush_D, flush_E, mc_done, mc_busy}
  typedef struct packed {
    logic          rst_n;
    logic [RS-1:0] ra, rb;
    logic          ua, ub, ld;
    logic [RS-1:0] rd;
    logic          mc, br;
    logic [6:0]    exp;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input int ra, input int rb, input logic ua,
                              input logic ub, input logic ld, input int rd, input logic mc,
                              input logic br, input logic [6:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.ra = RS'(ra); v.rb = RS'(rb); v.ua = ua; v.ub = ub; v.ld = ld;
    v.rd = RS'(rd); v.mc = mc; v.br = br; v.exp = exp;
    return v;
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  // age: -1 idle, otherwise cycles elapsed since the multicycle op issued
  int age [NI];
  int scnt[NI];
  int fcnt[NI];

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic lu;
    i_rst_n = v.rst_n; i_reg_a_select = v.ra; i_reg_b_select = v.rb;
    i_uses_a = v.ua; i_uses_b = v.ub; i_is_load_E = v.ld; i_reg_c_select_E = v.rd;
    i_mc_start_E = v.mc; i_branch_taken_E = v.br;
    @(negedge i_clk);
    lu = v.ld && (v.rd != 0) && ((v.ua && v.ra == v.rd) || (v.ub && v.rb == v.rd));
    for (int i = 0; i < NI; i++) begin
      int lat, an, smax;
      logic [6:0] e;
      lat = lat_of(i); smax = (1 << cw_of(i)) - 1; an = -1; e = '0;
      if (!v.rst_n) begin
        age[i] = -1; scnt[i] = 0; fcnt[i] = 0;
      end else if (age[i] < 0) begin
        if (v.br)      e = 7'b0001100;
        else if (v.mc) begin e = 7'b1110000; an = 0; end
        else if (lu)   e = 7'b1100100;
      end else begin
        an = age[i];
        e  = (an == lat - 1) ? 7'b0000010 : 7'b1110001;
      end
      chk7($sformatf("outs_u%0d", i), dout[i], e);
      chk32($sformatf("stall_cnt_u%0d", i), dsc[i], 32'(scnt[i]));
      chk32($sformatf("flush_cnt_u%0d", i), dfc[i], 32'(fcnt[i]));
      if (v.rst_n) begin
`ifdef HZD_PERF_EN
        if (e[6] && scnt[i] < smax) scnt[i]++;
        if (e[3] && fcnt[i] < smax) fcnt[i]++;
`endif
        age[i] = (an >= 0 && an < lat - 1) ? an + 1 : -1;
      end
    end
    if (use_tbl) chk7({"tbl_", tag}, dout[0], v.exp);
    if (tag.len() > 0)
      $display("txn %s: rst_n=%b mc=%b br=%b ld=%b rd=%0d -> u0 outs=%b", tag, v.rst_n, v.mc,
               v.br, v.ld, v.rd, dout[0]);
    @(posedge i_clk);
    #1;
  endtask

  vec_t tbl[23];
  vec_t idle;
  vec_t rv;

  initial begin
    for (int i = 0; i < NI; i++) begin age[i] = -1; scnt[i] = 0; fcnt[i] = 0; end
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    tbl[0]  = idle;
    tbl[1]  = mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 7'b1100100);
    tbl[2]  = mk(1, 5, 0, 1, 0, 0, 5, 0, 0, 7'b0000000);
    tbl[3]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 7'b0000000);
    tbl[4]  = mk(1, 5, 0, 0, 0, 1, 5, 0, 0, 7'b0000000);
    tbl[5]  = mk(1, 0, 7, 0, 1, 1, 7, 0, 0, 7'b1100100);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1110000);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1110001);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1110001);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000010);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1110000);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1110001);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1110001);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000010);
    tbl[14] = mk(1, 3, 0, 1, 0, 1, 3, 0, 1, 7'b0001100);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0001100);
    tbl[16] = idle;
    tbl[17] = mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 7'b1110000);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    for (int i = 19; i < 23; i++) tbl[i] = idle;

    #1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0), 1'b1, "reset0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0), 1'b1, "reset1");
    for (int i = 0; i < 23; i++) step(tbl[i], 1'b1, $sformatf("row%0d", i));

    // Perf saturation on the 4-bit instance: 20 consecutive stall cycles
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0), 1'b0, "sat_reset");
    for (int i = 0; i < 20; i++) step(mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 7'b1100100), 1'b1, "sat_stall");
    @(negedge i_clk);
`ifdef HZD_PERF_EN
    chk32("stall_sat_u0", dsc[0], 32'd15);
`else
    chk32("stall_off_u0", dsc[0], 32'd0);
`endif
    @(posedge i_clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      rv = mk($urandom_range(199) != 0, $urandom_range(3), $urandom_range(3),
              $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(3),
              $urandom_range(5) == 0, $urandom_range(7) == 0, 7'b0);
      step(rv, 1'b0, "");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hzd_ctrl.md
Name: hzd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W); sits beside the forwarding unit and resolves the hazards forwarding cannot.
- Handles three cases:
  - load-use bubbles;
  - fixed-latency multicycle execute ops (mul/div) that hold E;
  - taken-branch flushes.
- Drives per-stage stall and flush enables into the pipeline registers. Forwarding then resolves the remaining RAW cases.

Parameters:
REG_SELECT, 5, register index width
MC_LATENCY, 4, multicycle op latency in cycles, including the issue cycle; legal range 2..255
CNT_WIDTH, 16, width of performance counters

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_reg_a_select  in  REG_SELECT  rs1 of instruction in D
i_reg_b_select  in  REG_SELECT  rs2 of instruction in D
i_uses_a  in  1  D instruction reads rs1
i_uses_b  in  1  D instruction reads rs2
i_is_load_E  in  1  E instruction is a load
i_reg_c_select_E  in  REG_SELECT  rd of E instruction
i_mc_start_E  in  1  E instruction is a multicycle op
i_branch_taken_E  in  1  E resolved a taken branch/jump
o_stall_F  out  1  hold PC / F register
o_stall_D  out  1  hold D register
o_stall_E  out  1  hold E register
o_flush_D  out  1  load bubble into D on next edge
o_flush_E  out  1  load bubble into E on next edge
o_mc_done  out  1  multicycle result valid this cycle; E advances
o_mc_busy  out  1  state is MC_WAIT
o_stall_cycles  out  CNT_WIDTH  perf: cycles with o_stall_F=1
o_flush_count  out  CNT_WIDTH  perf: branch flush events

Behaviour:
- FSM states: RUN, MC_WAIT.
- Registered state: FSM state, latency counter (8 bit), done flag, perf counters.
- All outputs are combinational from registered state and current inputs.

Reset:
- Asynchronous on i_rst_n low.
- State goes to RUN; counter, done flag and perf counters go to 0.
- While in reset, every output is 0.
- A reset asserted mid-MC_WAIT aborts the op; no o_mc_done pulse follows.

RUN, in priority order:
1. Done cycle: if the done flag is set, o_mc_done=1, the flag clears, and i_mc_start_E is ignored this cycle (E still holds the completing op). No stalls are asserted.
2. Taken branch: i_branch_taken_E=1 -> o_flush_D=1, o_flush_E=1, no stalls. i_mc_start_E and the load-use check are ignored this cycle.
3. Multicycle start: i_mc_start_E=1 -> o_stall_F=o_stall_D=o_stall_E=1 this cycle.
   - MC_LATENCY=2: stay in RUN and set the done flag.
   - Otherwise: load the counter with MC_LATENCY-2 and go to MC_WAIT.
4. Load-use: i_is_load_E=1 and i_reg_c_select_E!=0 and ((i_uses_a and rs1==rd) or (i_uses_b and rs2==rd)) -> o_stall_F=1, o_stall_D=1, o_flush_E=1.
   - Lasts exactly one cycle, because the bubble removes the load from E.
5. Otherwise all stall and flush outputs are 0.

MC_WAIT:
- o_stall_F=o_stall_D=o_stall_E=1; o_mc_busy=1.
- Branch input, load-use check and i_mc_start_E are all ignored.
- Counter decrements each cycle. When counter==1, set the done flag and return to RUN.

Net timing:
- An op issued at cycle T0 stalls F/D/E for exactly MC_LATENCY-1 cycles (T0..T(MC_LATENCY-2)).
- o_mc_done=1 only at T(MC_LATENCY-1), with all stalls low.
- Back-to-back multicycle ops: the second one's i_mc_start_E is first honoured in the cycle after o_mc_done.

Other rules:
- Register 0 never causes a load-use hazard.
- o_flush_D and o_stall_D are never both 1.

Optional Feature:
- Macro: HZD_PERF_EN.
- With the macro defined:
  - o_stall_cycles increments on every cycle with o_stall_F=1.
  - o_flush_count increments on every cycle with o_flush_D=1.
  - Both saturate at all-ones and clear only on reset.
- Without the macro: no counter flops; both ports are tied to 0.

Test Plan:
- Load-use: E load rd=5, D rs1=5 with i_uses_a=1 -> exactly one cycle of stall_F=stall_D=flush_E=1; the same case with rd=0, or with i_uses_a=0, gives no stall.
- Multicycle, MC_LATENCY=4: i_mc_start_E at T0 -> stall_F/D/E=1 at T0..T2, o_mc_busy=1 at T1..T2, o_mc_done=1 at T3 only, with i_mc_start_E held high through T3 not restarting the op. Repeat with MC_LATENCY=2 -> one stall cycle, done at T1.
- Branch priority: i_branch_taken_E=1 with a simultaneous load-use match -> flush_D=flush_E=1 and no stalls; o_flush_count increments by 1 (HZD_PERF_EN defined).
- Branch input asserted during MC_WAIT -> ignored: no flush, and the stall sequence is unchanged.
- Reset mid-MC_WAIT: i_rst_n low at T1 of a MC_LATENCY=6 op -> all outputs 0 immediately; after release, state is RUN and no o_mc_done pulse occurs.
- Perf saturation with CNT_WIDTH=4 and HZD_PERF_EN defined: 20 stall cycles -> o_stall_cycles=15 and holds. Without the macro, both counters read 0.
